// File: rtl/key_filter_4.sv
// key_filter_4: four-channel push-button conditioner.
// Each active-low key is synchronised, debounced and edge-detected
// independently. The block produces a one-cycle press pulse, a one-cycle
// release pulse and a debounced "held down" level per key. Every output is a
// flop, so nothing combinational runs from key_in to the outputs.

module key_filter_4 #(
    parameter int              CNT_W   = 20,
    parameter logic [CNT_W-1:0] CNT_MAX = 20'd999_999
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic [3:0] key_in,
    output logic [3:0] key_flag,
    output logic [3:0] key_release,
    output logic [3:0] key_state
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        P_FILT = 2'd1,
        DOWN   = 2'd2,
        R_FILT = 2'd3
    } state_t;

    logic [3:0]       sync1;
    logic [3:0]       sync2;
    state_t           state [4];
    logic [CNT_W-1:0] cnt   [4];

    // Two-flop synchroniser; it resets to "released" so a key that is already
    // held at reset release still goes through the full filter.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1 <= 4'b1111;
            sync2 <= 4'b1111;
        end else begin
            // NOTE: flops use non-blocking assignments so every register
            // samples the pre-edge value; blocking here would collapse the
            // two stages into one.
            sync1 <= key_in;
            sync2 <= sync1;
        end
    end

    // Per-key debounce FSM with registered pulse and level outputs.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            // NOTE: the state and counter arrays are only a few flops per key
            // and the FSM must come up in IDLE, so they are reset like any
            // other control register.
            for (int i = 0; i < 4; i++) begin
                state[i] <= IDLE;
                cnt[i]   <= '0;
            end
            key_flag    <= 4'b0000;
            key_release <= 4'b0000;
            key_state   <= 4'b0000;
        end else begin
            for (int i = 0; i < 4; i++) begin
                // Pulses are one cycle wide: cleared by default every cycle.
                key_flag[i]    <= 1'b0;
                key_release[i] <= 1'b0;

                case (state[i])
                    IDLE: begin
                        if (!sync2[i]) begin
                            state[i] <= P_FILT;
                            cnt[i]   <= '0;
                        end
                    end

                    P_FILT: begin
                        if (sync2[i]) begin
                            // Bounce: the key went high again before it was
                            // stable long enough.
                            state[i] <= IDLE;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == CNT_MAX) begin
                            state[i]     <= DOWN;
                            key_flag[i]  <= 1'b1;
                            key_state[i] <= 1'b1;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end

                    DOWN: begin
                        if (sync2[i]) begin
                            state[i] <= R_FILT;
                            cnt[i]   <= '0;
                        end
                    end

                    R_FILT: begin
                        if (!sync2[i]) begin
                            // Bounce on release: still considered held.
                            state[i] <= DOWN;
                            cnt[i]   <= '0;
                        end else if (cnt[i] == CNT_MAX) begin
                            state[i]       <= IDLE;
                            key_release[i] <= 1'b1;
                            key_state[i]   <= 1'b0;
                        end else begin
                            cnt[i] <= cnt[i] + CNT_W'(1);
                        end
                    end

                    default: begin
                        state[i] <= IDLE;
                        cnt[i]   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_key_filter_4.sv
// tb_key_filter_4: scoreboard bench for key_filter_4 with a short filter.
// Stimulus tasks push the cycle at which each pulse must appear; a monitor
// running on the falling edge pops due entries and compares pulses and the
// debounced level every cycle.

module tb_key_filter_4;

    localparam int CNT_W   = 20;
    localparam int CNT_MAX = 3;
    // Edges from the first low sample to the cycle the pulse is visible.
    localparam int LAT     = CNT_MAX + 4;

    logic       sys_clk;
    logic       sys_rst_n;
    logic [3:0] key_in;
    logic [3:0] key_flag;
    logic [3:0] key_release;
    logic [3:0] key_state;

    typedef struct {
        int         cyc;
        logic [3:0] flag;
        logic [3:0] rel;
    } ev_t;

    ev_t        sb [$];
    logic [3:0] exp_state;
    int         cyc;
    int         total;
    int         bad;

    key_filter_4 #(
        .CNT_W   (CNT_W),
        .CNT_MAX (20'd3)
    ) dut (
        .sys_clk     (sys_clk),
        .sys_rst_n   (sys_rst_n),
        .key_in      (key_in),
        .key_flag    (key_flag),
        .key_release (key_release),
        .key_state   (key_state)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    // Edge counter: after the Nth rising edge cyc == N.
    initial cyc = 0;
    always @(posedge sys_clk) cyc++;

    initial begin
        #100us;
        $display("FAIL watchdog: time limit reached, got=running required=finished");
        $fatal(1, "watchdog");
    end

    // Falling-edge monitor: merges every event due this cycle and compares.
    task automatic run_monitor();
        logic [3:0] ef;
        logic [3:0] er;
        forever begin
            @(negedge sys_clk);
            ef = 4'b0000;
            er = 4'b0000;
            for (int i = sb.size() - 1; i >= 0; i--) begin
                if (sb[i].cyc == cyc) begin
                    ef |= sb[i].flag;
                    er |= sb[i].rel;
                    sb.delete(i);
                end else if (sb[i].cyc < cyc) begin
                    total++;
                    bad++;
                    $display("FAIL overdue_event cyc=%0d got=missing required_at=%0d", cyc, sb[i].cyc);
                    sb.delete(i);
                end
            end
            exp_state = (exp_state | ef) & ~er;
            total++;
            if (key_flag !== ef) begin
                bad++;
                $display("FAIL key_flag cyc=%0d got=%b required=%b", cyc, key_flag, ef);
            end
            total++;
            if (key_release !== er) begin
                bad++;
                $display("FAIL key_release cyc=%0d got=%b required=%b", cyc, key_release, er);
            end
            total++;
            if (key_state !== exp_state) begin
                bad++;
                $display("FAIL key_state cyc=%0d got=%b required=%b", cyc, key_state, exp_state);
            end
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    // Press keys in mask (drive low) and expect one flag LAT edges later.
    task automatic press(input logic [3:0] mask);
        ev_t e;
        key_in = key_in & ~mask;
        e.cyc  = cyc + LAT;
        e.flag = mask;
        e.rel  = 4'b0000;
        sb.push_back(e);
    endtask

    task automatic release_keys(input logic [3:0] mask);
        ev_t e;
        key_in = key_in | mask;
        e.cyc  = cyc + LAT;
        e.flag = 4'b0000;
        e.rel  = mask;
        sb.push_back(e);
    endtask

    task automatic test_reset();
        sys_rst_n = 1'b0;
        key_in    = 4'b0000;
        wait_cyc(3);
        total++;
        if ({key_flag, key_release, key_state} !== 12'h000) begin
            bad++;
            $display("FAIL reset_outputs got=%b_%b_%b required=0000_0000_0000",
                     key_flag, key_release, key_state);
        end
        // Keys held through reset release: all four pulse together.
        sys_rst_n = 1'b1;
        begin
            ev_t e;
            e.cyc  = cyc + LAT;
            e.flag = 4'b1111;
            e.rel  = 4'b0000;
            sb.push_back(e);
        end
        wait_cyc(10);
        release_keys(4'b1111);
        wait_cyc(10);
    endtask

    task automatic test_clean_press();
        press(4'b0010);
        wait_cyc(10);
        total++;
        if (key_state !== 4'b0010) begin
            bad++;
            $display("FAIL clean_press_held got=%b required=0010", key_state);
        end
        release_keys(4'b0010);
        wait_cyc(10);
        total++;
        if (key_state !== 4'b0000) begin
            bad++;
            $display("FAIL clean_release_level got=%b required=0000", key_state);
        end
    endtask

    task automatic test_bounce();
        // key 0: low 2, high 1, low 2, high 1, then steady low.
        logic       lvl [6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        for (int i = 0; i < 6; i++) begin
            key_in[0] = lvl[i];
            wait_cyc(1);
        end
        press(4'b0001);
        wait_cyc(10);
        release_keys(4'b0001);
        wait_cyc(10);
    endtask

    task automatic test_release_bounce();
        press(4'b0100);
        wait_cyc(10);
        key_in[2] = 1'b1;
        wait_cyc(2);
        key_in[2] = 1'b0;
        wait_cyc(10);
        total++;
        if (key_state[2] !== 1'b1) begin
            bad++;
            $display("FAIL release_bounce_level got=%b required=1", key_state[2]);
        end
        release_keys(4'b0100);
        wait_cyc(10);
    endtask

    task automatic test_simultaneous();
        press(4'b1111);
        wait_cyc(10);
        release_keys(4'b1111);
        wait_cyc(10);
    endtask

    task automatic test_staggered();
        for (int i = 0; i < 4; i++) begin
            logic [3:0] m;
            m = 4'b0001 << i;
            press(m);
            wait_cyc(1);
        end
        wait_cyc(10);
        release_keys(4'b1111);
        wait_cyc(10);
    endtask

    task automatic test_async_reset();
        ev_t e;
        press(4'b1000);
        wait_cyc(10);
        press(4'b0001);
        wait_cyc(4);
        // Key 3 is in DOWN, key 0 mid P_FILT; reset between clock edges.
        @(posedge sys_clk);
        #2;
        total++;
        if (key_state !== 4'b1000) begin
            bad++;
            $display("FAIL pre_reset_level got=%b required=1000", key_state);
        end
        sys_rst_n = 1'b0;
        sb.delete();
        exp_state = 4'b0000;
        #1;
        total++;
        if ({key_flag, key_release, key_state} !== 12'h000) begin
            bad++;
            $display("FAIL async_reset_clear got=%b_%b_%b required=0000_0000_0000",
                     key_flag, key_release, key_state);
        end
        wait_cyc(3);
        sys_rst_n = 1'b1;
        e.cyc  = cyc + LAT;
        e.flag = 4'b1001;
        e.rel  = 4'b0000;
        sb.push_back(e);
        wait_cyc(10);
        release_keys(4'b1001);
        wait_cyc(10);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        exp_state = 4'b0000;
        sys_rst_n = 1'b0;
        key_in    = 4'b0000;
        fork
            run_monitor();
        join_none
        test_reset();
        test_clean_press();
        test_bounce();
        test_release_bounce();
        test_simultaneous();
        test_staggered();
        test_async_reset();
        wait_cyc(5);
        total++;
        if (sb.size() != 0) begin
            bad++;
            $display("FAIL scoreboard_drain got=%0d required=0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
